// File: rtl/bmc_line_encoder_if.sv
// ============================================================================
// Module   : bmc_line_encoder_if
// Purpose  : Subframe valid/ready handshake into the BMC line encoder.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface bmc_line_encoder_if;
  logic [1:0]  sub_pre;
  logic [27:0] sub_data;
  logic        sub_valid;
  logic        sub_ready;

  modport master (output sub_pre, output sub_data, output sub_valid, input sub_ready);
  modport slave  (input sub_pre, input sub_data, input sub_valid, output sub_ready);
endinterface

`default_nettype wire

// File: rtl/bmc_line_encoder.sv
// ============================================================================
// Module   : bmc_line_encoder
// Purpose  : Serialises buffered S/PDIF-style subframes onto the line as
//            biphase-mark code with preamble insertion and parity generation.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bmc_line_encoder #(
  parameter int CLKS_PER_HALFBIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  bmc_line_encoder_if.slave  sub,
  output logic               line_out,
  output logic               busy,
  output logic               underrun
);

  localparam int          CNT_W      = $clog2(CLKS_PER_HALFBIT);
  localparam logic [7:0]  c_pre_z    = 8'b11101000;
  localparam logic [7:0]  c_pre_x    = 8'b11100010;
  localparam logic [7:0]  c_pre_y    = 8'b11100100;
  localparam logic [27:0] c_body_msk = 28'h7FF_FFFF;

  logic             r_hold_full;
  logic [1:0]       r_hold_pre;
  logic [27:0]      r_hold_data;

  logic             r_busy;
  logic             r_line;
  logic             r_underrun;
  logic             r_lp;
  logic [7:0]       r_pre;
  logic [27:0]      r_shift;
  logic [5:0]       r_half;
  logic [CNT_W-1:0] r_cnt;

  logic             w_cell_end;
  logic             w_frame_end;
  logic             w_load;
  logic             w_accept;
  logic [5:0]       w_nh;
  logic [7:0]       w_pat;
  logic [27:0]      w_body;
  logic             w_next_line;

  assign w_accept    = sub.sub_valid && !r_hold_full;
  assign w_cell_end  = r_busy && (r_cnt == CNT_W'(CLKS_PER_HALFBIT - 1));
  assign w_frame_end = w_cell_end && (r_half == 6'd63);
  assign w_load      = r_hold_full && (!r_busy || w_frame_end);
  assign w_nh        = r_half + 6'd1;
  // Upstream parity slot is discarded; it is regenerated below.
  assign w_body      = r_hold_data & c_body_msk;

  always_comb begin
    w_pat = c_pre_x;
    case (r_hold_pre)
      2'd0:    w_pat = c_pre_z;
      2'd2:    w_pat = c_pre_y;
      default: w_pat = c_pre_x;
    endcase
  end

  // Level for the half-cell that starts on the next clock.
  always_comb begin
    w_next_line = r_line;
    if (w_nh < 6'd8) begin
      w_next_line = r_pre[~w_nh[2:0]] ^ r_lp;
    end else if (!w_nh[0]) begin
      w_next_line = ~r_line;
    end else begin
      w_next_line = r_line ^ r_shift[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_full <= 1'b0;
      r_hold_pre  <= 2'd0;
      r_hold_data <= '0;
      r_busy      <= 1'b0;
      r_line      <= 1'b0;
      r_underrun  <= 1'b0;
      r_lp        <= 1'b0;
      r_pre       <= '0;
      r_shift     <= '0;
      r_half      <= '0;
      r_cnt       <= '0;
    end else begin
      r_underrun <= 1'b0;
      if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold_pre  <= sub.sub_pre;
        r_hold_data <= sub.sub_data;
      end
      if (w_load) begin
        r_hold_full <= 1'b0;
        r_busy      <= 1'b1;
        r_half      <= '0;
        r_cnt       <= '0;
        r_pre       <= w_pat;
        r_lp        <= r_line;
        r_line      <= w_pat[7] ^ r_line;
        r_shift     <= {^w_body, w_body[26:0]};
      end else if (w_frame_end) begin
        r_busy     <= 1'b0;
        r_underrun <= 1'b1;
        r_half     <= '0;
        r_cnt      <= '0;
      end else if (w_cell_end) begin
        r_cnt  <= '0;
        r_half <= w_nh;
        r_line <= w_next_line;
        if (w_nh >= 6'd8 && w_nh[0]) begin
          r_shift <= r_shift >> 1;
        end
      end else if (r_busy) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign sub.sub_ready = ~r_hold_full;
  assign line_out      = r_line;
  assign busy          = r_busy;
  assign underrun      = r_underrun;

endmodule

`default_nettype wire

// File: doc/bmc_line_encoder.md
# bmc_line_encoder

Downstream stage of subframe assembly in the optical audio transmit path. Accepts one S/PDIF-style subframe at a time (preamble select plus 28 payload slots) over a valid/ready handshake and holds it in a one-entry buffer. It serialises the subframe onto the line as biphase-mark code. It inserts the BMC-violating preamble, computes the parity slot itself, and maintains line polarity across subframes. `line_out` drives the optical transmitter.

## Interface

- `CLKS_PER_HALFBIT`, default 4: clk cycles per half-bit cell; legal values are ≥2.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `sub_pre` in 2: preamble select.
  - 0 = Z (block start), 1 = X (channel A), 2 = Y (channel B).
  - 3 is treated as X.
- `sub_data` in 28: subframe slots 4..31.
  - `sub_data[0]` = slot 4, sent first.
  - `sub_data[27]` (parity) is ignored.
- `sub_valid` in 1: upstream offers `sub_pre`/`sub_data`.
- `sub_ready` out 1: holding register empty; transfer occurs when `sub_valid && sub_ready`.
- `line_out` out 1: BMC line level.
- `busy` out 1: a subframe is being serialised.
- `underrun` out 1: single-cycle pulse when a subframe ends with no successor buffered.

## Operation

- **Storage:** one holding register (`hold_full` flag) plus one shift/serialiser register.
  - `sub_ready = ~hold_full`. There is no same-cycle bypass.
- **Load rule:** the serialiser loads from hold in either of two cycles:
  - when `~busy && hold_full`;
  - on the last clock of half-cell 63 when `hold_full`.
  - Loading clears `hold_full`.
- **Subframe layout:** 64 half-cells, indexed 0..63.
  - Half-cells 0..7 are the preamble.
  - Half-cells 8..63 are slots 4..31, two half-cells per slot.
- **Parity:** slot 31 = XOR of slots 4..30, computed at load, so slots 4..31 have even parity.
- **Preamble patterns** (half-cell 0 is the MSB):
  - Z = 8'b11101000
  - X = 8'b11100010
  - Y = 8'b11100100
  - Let `Lp` be the `line_out` level immediately before half-cell 0. Emitted half-cell k = pattern[7-k] XOR `Lp`.
- **Data cells:**
  - First half of every slot: `line_out` inverts.
  - Second half: `line_out` inverts if the slot bit is 1, holds if 0.
- **Half-cell timing:** a half-cell counter runs 0..`CLKS_PER_HALFBIT`-1 only while `busy`. `line_out` updates only on the first clock of each half-cell.
- **End of subframe with `hold_full`:** the next subframe's half-cell 0 begins on the very next clock, with no gap.
- **End of subframe with `~hold_full`:**
  - `busy` falls and `underrun` pulses for 1 cycle.
  - `line_out` holds its last level; no transitions occur while idle.
- **Reset:**
  - `line_out` = 0, `busy` = 0, `underrun` = 0, `hold_full` = 0 (so `sub_ready` = 1).
  - Counters are cleared and inputs are ignored while `rst` is high.
  - Reset mid-subframe aborts immediately; the next subframe starts with `Lp` = 0.

## Timing

- **Idle acceptance at cycle t:**
  - t+1: `sub_ready` = 0; serialiser loads.
  - t+2: `busy` = 1, `line_out` shows half-cell 0, and `sub_ready` = 1.
- **Subframe duration:** exactly 64·`CLKS_PER_HALFBIT` cycles.
- **Back-to-back:** a word accepted any time before the final clock of half-cell 63 is sent gap-free.
  - A word accepted in that final clock itself is not loaded until the following cycle. That case counts as an underrun, and the word starts 2 cycles later.
- **`underrun`:** asserted in the cycle `busy` falls.
- **Simultaneous load and accept:** cannot occur, because `sub_ready` is low while hold is full.

## Test plan

- **Reset values:** during and after `rst`, `line_out`=0, `busy`=0, `sub_ready`=1, `underrun`=0. Mid-subframe `rst` returns to these values next cycle, and the next X frame starts with pattern 11100010.
- **Single frame:** `CLKS_PER_HALFBIT`=4, idle, X, `sub_data`=0, accepted at t.
  - From t+2, half-cells are 11100010 then 28 slots of 11,00,11,…,00.
  - `busy` lasts 256 cycles, then `underrun` pulses and `line_out` stays 0.
- **Ones and parity:** Y, `sub_data[0]`=1 and `sub_data[1]`=1, all others 0. Slots 4 and 5 show mid-cell transitions, and slot 31 parity = 0.
  - Same test with only `sub_data[0]`=1: slot 31 shows a mid-cell transition (parity = 1).
- **Polarity:** a frame ending with `line_out`=1 followed immediately by Z must emit the inverted pattern 00010111.
- **Back-to-back:** stream 4 subframes Z,Y,X,Y with `sub_valid` held high.
  - No idle cycles occur, `underrun` never pulses, and `sub_ready` pulses once per subframe.
- **Late offer:** present the next word exactly in the last clock of half-cell 63.
  - `underrun` pulses, and the next half-cell 0 appears 2 cycles after acceptance.
